axis_fifo_flagged: RTL and testbench

//  Parametrised AXI-Stream FIFO; successor of the plain AXIS FIFO used between pipeline stages.

---
 rtl/axis_fifo_flagged.sv | 106 ++++++++++
 tb/tb_axis_fifo_flagged.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_flagged.sv
// AXI-Stream FIFO with occupancy count, almost-full/almost-empty flags, synchronous flush and
// arbitrary (non-power-of-two) depth. Define AXIS_FIFO_FLAGGED_LAST_EN to carry a TLAST bit per entry.
module axis_fifo_flagged #(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int ALMOST_FULL  = 12,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic                                 input_valid,
   output logic                                 input_ready,
   input  logic [DATA_WIDTH-1:0]                input_data,
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
   input  logic                                 input_last,
   output logic                                 output_last,
`endif
   output logic                                 output_valid,
   input  logic                                 output_ready,
   output logic [DATA_WIDTH-1:0]                output_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      occupancy,
   output logic                                 almost_full,
   output logic                                 almost_empty
);

   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
   localparam int ENTRY_W = DATA_WIDTH + 1;
`else
   localparam int ENTRY_W = DATA_WIDTH;
`endif

   localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] OCC_AFULL  = OCC_W'(ALMOST_FULL);
   localparam logic [OCC_W-1:0] OCC_AEMPTY = OCC_W'(ALMOST_EMPTY);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);

   generate
      if (FIFO_DEPTH < 2) begin : g_bad_depth
         $error("axis_fifo_flagged: FIFO_DEPTH must be at least 2");
      end
      if (ALMOST_FULL > FIFO_DEPTH) begin : g_bad_afull
         $error("axis_fifo_flagged: ALMOST_FULL must not exceed FIFO_DEPTH");
      end
      if (ALMOST_EMPTY >= FIFO_DEPTH) begin : g_bad_aempty
         $error("axis_fifo_flagged: ALMOST_EMPTY must be below FIFO_DEPTH");
      end
   endgenerate

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [OCC_W-1:0]   occ;
   logic [ENTRY_W-1:0] entry_in;
   logic [ENTRY_W-1:0] head;
   logic               write_en;
   logic               read_en;

   // Handshake: a beat transfers on a rising edge where valid and ready are both high. Ready and
   // valid come only from registered occupancy, so neither depends on the partner's signal.
   assign input_ready  = (occ != OCC_FULL);
   assign output_valid = (occ != '0);
   assign write_en     = input_valid & input_ready;
   assign read_en      = output_valid & output_ready;

`ifdef AXIS_FIFO_FLAGGED_LAST_EN
   assign entry_in    = {input_last, input_data};
   assign output_last = head[DATA_WIDTH];
`else
   assign entry_in    = input_data;
`endif
   assign head         = mem[rd_ptr];
   assign output_data  = head[DATA_WIDTH-1:0];
   assign occupancy    = occ;
   assign almost_full  = (occ >= OCC_AFULL);
   assign almost_empty = (occ <= OCC_AEMPTY);

   // Explicit wrap keeps pointers inside the array for any depth.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (write_en) wr_ptr <= ptr_next(wr_ptr);
         if (read_en)  rd_ptr <= ptr_next(rd_ptr);
         case ({write_en, read_en})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage is deliberately not reset; a flushed word is never written.
   always_ff @(posedge clk) begin
      if (write_en && rst && !flush) mem[wr_ptr] <= entry_in;
   end

endmodule

// File: tb/tb_axis_fifo_flagged.sv
// Directed bench for axis_fifo_flagged: a depth-16 instance for fill/drain/full/flush cases and a
// depth-5 instance streaming random traffic, both checked against a queue-based reference model.
module tb_axis_fifo_flagged;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // depth-16 instance (A)
   logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, af_a, ae_a;
   logic [31:0] in_data_a, out_data_a;
   logic [4:0]  occ_a;
   // depth-5 instance (B)
   logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, af_b, ae_b;
   logic [31:0] in_data_b, out_data_b;
   logic [2:0]  occ_b;
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
   logic        in_last_a, out_last_a, in_last_b, out_last_b;
`endif

   axis_fifo_flagged #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .ALMOST_FULL(12), .ALMOST_EMPTY(2)) dut_a (
      .clk(clk), .rst(rst), .flush(flush_a),
      .input_valid(in_valid_a), .input_ready(in_ready_a), .input_data(in_data_a),
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
      .input_last(in_last_a), .output_last(out_last_a),
`endif
      .output_valid(out_valid_a), .output_ready(out_ready_a), .output_data(out_data_a),
      .occupancy(occ_a), .almost_full(af_a), .almost_empty(ae_a)
   );

   axis_fifo_flagged #(.DATA_WIDTH(32), .FIFO_DEPTH(5), .ALMOST_FULL(4), .ALMOST_EMPTY(1)) dut_b (
      .clk(clk), .rst(rst), .flush(flush_b),
      .input_valid(in_valid_b), .input_ready(in_ready_b), .input_data(in_data_b),
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
      .input_last(in_last_b), .output_last(out_last_b),
`endif
      .output_valid(out_valid_b), .output_ready(out_ready_b), .output_data(out_data_b),
      .occupancy(occ_b), .almost_full(af_b), .almost_empty(ae_b)
   );

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   logic [32:0] exp_a[$];
   logic [32:0] exp_b[$];
   int          occ_m_a = 0;
   int          occ_m_b = 0;
   bit          acc_a;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare instance A against the model, then advance model and clock by one cycle.
   task automatic step_a();
      bit wr, rd;
      check("a_occupancy", 64'(occ_a), 64'(occ_m_a));
      check("a_input_ready", 64'(in_ready_a), 64'(occ_m_a != 16));
      check("a_output_valid", 64'(out_valid_a), 64'(occ_m_a != 0));
      check("a_almost_full", 64'(af_a), 64'(occ_m_a >= 12));
      check("a_almost_empty", 64'(ae_a), 64'(occ_m_a <= 2));
      if (occ_m_a != 0) check("a_output_data", 64'(out_data_a), 64'(exp_a[0][31:0]));
      acc_a = 1'b0;
      if (flush_a) begin
         exp_a.delete();
         occ_m_a = 0;
      end else begin
         rd = out_ready_a && (occ_m_a != 0);
         wr = in_valid_a && (occ_m_a != 16);
         if (rd) void'(exp_a.pop_front());
         if (wr) exp_a.push_back({1'b0, in_data_a});
         occ_m_a = occ_m_a + int'(wr) - int'(rd);
         acc_a = wr;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent, got, cyc;
      logic [31:0] next_val;
      bit wr, rd;

      rst = 1'b0;
      flush_a = 0; in_valid_a = 0; out_ready_a = 0; in_data_a = '0;
      flush_b = 0; in_valid_b = 0; out_ready_b = 0; in_data_b = '0;
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
      in_last_a = 0; in_last_b = 0;
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // reset state on both instances
      check("b_reset_ready", 64'(in_ready_b), 64'd1);
      check("b_reset_valid", 64'(out_valid_b), 64'd0);
      check("b_reset_occ", 64'(occ_b), 64'd0);
      step_a();

      // fill: 17 offers, the last one must be refused
      for (int i = 0; i < 17; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = 32'(i);
         step_a();
      end
      in_valid_a = 1'b0;
      check("a_full_occ", 64'(occ_a), 64'd16);
      check("a_full_ready", 64'(in_ready_a), 64'd0);

      // drain in order
      out_ready_a = 1'b1;
      for (int i = 0; i < 17; i++) step_a();
      check("a_drained_valid", 64'(out_valid_a), 64'd0);

      // full with simultaneous read and write
      out_ready_a = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = 32'(200 + i);
         step_a();
      end
      next_val    = 32'd216;
      out_ready_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data_a = next_val;
         step_a();
         if (acc_a) next_val++;
         if (i == 0) check("a_full_read_occ", 64'(occ_a), 64'd15);
      end
      check("a_rw_occ_hold", 64'(occ_a), 64'd15);
      in_valid_a = 1'b0;
      for (int i = 0; i < 16; i++) step_a();
      check("a_rw_drained", 64'(out_valid_a), 64'd0);

      // flush at occupancy 7 with a word offered in the same cycle
      out_ready_a = 1'b0;
      for (int i = 0; i < 7; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = 32'(100 + i);
         step_a();
      end
      check("a_preflush_occ", 64'(occ_a), 64'd7);
      flush_a   = 1'b1;
      in_data_a = 32'hDEADBEEF;
      step_a();
      flush_a   = 1'b0;
      check("a_flush_occ", 64'(occ_a), 64'd0);
      check("a_flush_valid", 64'(out_valid_a), 64'd0);
      in_data_a = 32'hA5A5A5A5;
      step_a();
      in_valid_a  = 1'b0;
      out_ready_a = 1'b1;
      check("a_flush_first_word", 64'(out_data_a), 64'hA5A5A5A5);
      for (int i = 0; i < 3; i++) step_a();

      // depth-5 random stream of 40 words
      sent = 0; got = 0; cyc = 0;
      while (got < 40 && cyc < 3000) begin
         in_valid_b  = (sent < 40) && ($urandom_range(0, 3) != 0);
         in_data_b   = 32'(sent) ^ 32'h5000_0000;
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
         in_last_b   = (sent % 8) == 7;
`endif
         out_ready_b = ($urandom_range(0, 2) != 0);
         check("b_occupancy", 64'(occ_b), 64'(occ_m_b));
         check("b_occ_bound", 64'(occ_b <= 3'd5), 64'd1);
         check("b_input_ready", 64'(in_ready_b), 64'(occ_m_b != 5));
         check("b_output_valid", 64'(out_valid_b), 64'(occ_m_b != 0));
         check("b_almost_full", 64'(af_b), 64'(occ_m_b >= 4));
         check("b_almost_empty", 64'(ae_b), 64'(occ_m_b <= 1));
         if (occ_m_b != 0) begin
            check("b_output_data", 64'(out_data_b), 64'(exp_b[0][31:0]));
`ifdef AXIS_FIFO_FLAGGED_LAST_EN
            check("b_output_last", 64'(out_last_b), 64'(exp_b[0][32]));
`endif
         end
         rd = out_ready_b && (occ_m_b != 0);
         wr = in_valid_b && (occ_m_b != 5);
         if (rd) begin
            void'(exp_b.pop_front());
            got++;
         end
         if (wr) begin
            exp_b.push_back({((sent % 8) == 7), 32'(sent) ^ 32'h5000_0000});
            sent++;
         end
         occ_m_b = occ_m_b + int'(wr) - int'(rd);
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid_b = 1'b0;
      check("b_words_received", 64'(got), 64'd40);
      check("b_end_valid", 64'(out_valid_b), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
